// File: rtl/bp_be_fe_queue_ckpt.sv
// bp_be_fe_queue_ckpt
//   Front-end to back-end instruction queue with a commit checkpoint.
//   The BE dequeues speculatively (yumi). Dequeued entries stay in storage
//   until they are committed. A roll replays every dequeued but uncommitted
//   entry, and a clear discards everything.
//
// Parameters
//   width_p : bits per entry
//   els_p   : entry count (power of two, >= 2)
//
// Ports
//   clk_i            in   clock, rising edge
//   reset_n_i        in   asynchronous active-low reset
//   fe_queue_i       in   entry from the FE
//   fe_queue_v_i     in   entry valid (ready/valid)
//   fe_queue_ready_o out  space available
//   fe_queue_o       out  entry at the read pointer
//   fe_queue_v_o     out  fe_queue_o is valid
//   fe_queue_yumi_i  in   BE consumes fe_queue_o (speculative dequeue)
//   commit_i         in   retire the oldest dequeued entry
//   roll_i           in   rewind the read pointer to the checkpoint
//   clr_i            in   discard all entries (highest priority)
//   count_o          out  occupancy, uncommitted entries included
//
// Configuration
//   BP_FE_QUEUE_BYPASS_EN : when defined, an enqueue into an empty queue is
//   presented on fe_queue_o in the same cycle. The entry is still written to
//   storage, so it can be replayed by a roll.

module bp_be_fe_queue_ckpt #(
    parameter int width_p = 128,
    parameter int els_p   = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [width_p-1:0]         fe_queue_i,
    input  logic                       fe_queue_v_i,
    output logic                       fe_queue_ready_o,
    output logic [width_p-1:0]         fe_queue_o,
    output logic                       fe_queue_v_o,
    input  logic                       fe_queue_yumi_i,
    input  logic                       commit_i,
    input  logic                       roll_i,
    input  logic                       clr_i,
    output logic [$clog2(els_p):0]     count_o
);

    localparam int ptr_w = $clog2(els_p) + 1;
    localparam int idx_w = ptr_w - 1;

    // The pointer MSB is a wrap bit. The low bits index storage.
    logic [ptr_w-1:0]   wptr_q, wptr_d;
    logic [ptr_w-1:0]   rptr_q, rptr_d;
    logic [ptr_w-1:0]   cptr_q, cptr_d;
    logic [ptr_w-1:0]   cptr_post;
    logic [ptr_w-1:0]   occ;
    logic [width_p-1:0] mem_q [els_p];

    logic full;
    logic enq;
    logic deq;
    logic commit_ok;
    logic v_reg;

    // Occupancy is counted from the checkpoint. Dequeued entries still
    // hold their slots until they are committed.
    assign occ              = wptr_q - cptr_q;
    assign full             = (occ == ptr_w'(els_p));
    assign fe_queue_ready_o = ~full;
    assign count_o          = occ;

    assign enq   = fe_queue_v_i & fe_queue_ready_o;
    assign v_reg = (rptr_q != wptr_q);

`ifdef BP_FE_QUEUE_BYPASS_EN
    logic byp;
    // Bypass only when nothing is waiting. A clear or a roll in the same
    // cycle would make the forwarded entry stale or ambiguous.
    assign byp          = (rptr_q == wptr_q) & enq & ~clr_i & ~roll_i;
    assign fe_queue_v_o = v_reg | byp;
    assign fe_queue_o   = byp ? fe_queue_i : mem_q[rptr_q[idx_w-1:0]];
`else
    assign fe_queue_v_o = v_reg;
    assign fe_queue_o   = mem_q[rptr_q[idx_w-1:0]];
`endif

    assign deq       = fe_queue_yumi_i & fe_queue_v_o;
    // Compare against the current rptr. An entry dequeued in this same
    // cycle cannot also be committed in this cycle.
    assign commit_ok = commit_i & (cptr_q != rptr_q);
    assign cptr_post = cptr_q + ptr_w'(commit_ok);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cptr_d = cptr_q;
        if (clr_i) begin
            wptr_d = wptr_q;
            rptr_d = wptr_q;
            cptr_d = wptr_q;
        end else begin
            wptr_d = wptr_q + ptr_w'(enq);
            cptr_d = cptr_post;
            // A roll replays from the checkpoint after this cycle's commit.
            // Any same-cycle yumi is dropped.
            if (roll_i) begin
                rptr_d = cptr_post;
            end else begin
                rptr_d = rptr_q + ptr_w'(deq);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    // Storage has no reset. Validity comes only from the pointers.
    always_ff @(posedge clk_i) begin
        if (enq && !clr_i) begin
            mem_q[wptr_q[idx_w-1:0]] <= fe_queue_i;
        end
    end

endmodule

// File: tb/tb_bp_be_fe_queue_ckpt.sv
module tb_bp_be_fe_queue_ckpt;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic [127:0] fe_queue_i;
    logic         fe_queue_v_i;
    logic         fe_queue_ready_o;
    logic [127:0] fe_queue_o;
    logic         fe_queue_v_o;
    logic         fe_queue_yumi_i;
    logic         commit_i;
    logic         roll_i;
    logic         clr_i;
    logic [3:0]   count_o;

    int n_cmp = 0;
    int n_err = 0;

    bp_be_fe_queue_ckpt #(.width_p(128), .els_p(8)) dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .fe_queue_i       (fe_queue_i),
        .fe_queue_v_i     (fe_queue_v_i),
        .fe_queue_ready_o (fe_queue_ready_o),
        .fe_queue_o       (fe_queue_o),
        .fe_queue_v_o     (fe_queue_v_o),
        .fe_queue_yumi_i  (fe_queue_yumi_i),
        .commit_i         (commit_i),
        .roll_i           (roll_i),
        .clr_i            (clr_i),
        .count_o          (count_o)
    );

    always #5 clk_i = ~clk_i;

    // Apply one cycle of inputs at a negedge, step to the next negedge, then idle.
    task automatic drive(input logic v, input logic [127:0] d, input logic y,
                         input logic c, input logic r, input logic cl);
        fe_queue_v_i    = v;
        fe_queue_i      = d;
        fe_queue_yumi_i = y;
        commit_i        = c;
        roll_i          = r;
        clr_i           = cl;
        @(posedge clk_i);
        @(negedge clk_i);
        fe_queue_v_i    = 1'b0;
        fe_queue_yumi_i = 1'b0;
        commit_i        = 1'b0;
        roll_i          = 1'b0;
        clr_i           = 1'b0;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        #1;
        n_cmp++; if (fe_queue_v_o !== 1'b0) begin n_err++; $display("FAIL reset_v_o: got %b want 0", fe_queue_v_o); end
        n_cmp++; if (fe_queue_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", fe_queue_ready_o); end
        n_cmp++; if (count_o !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count_o); end
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) drive(1'b1, 128'hA0 + 128'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (fe_queue_ready_o !== 1'b0) begin n_err++; $display("FAIL fill_ready: got %b want 0", fe_queue_ready_o); end
        n_cmp++; if (count_o !== 4'd8) begin n_err++; $display("FAIL fill_count: got %0d want 8", count_o); end
        n_cmp++; if (fe_queue_o !== 128'hA0) begin n_err++; $display("FAIL fill_head: got %h want a0", fe_queue_o); end
        // The 9th enqueue is blocked while full.
        drive(1'b1, 128'hA8, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (count_o !== 4'd8) begin n_err++; $display("FAIL fill_blocked_count: got %0d want 8", count_o); end
        // A dequeue alone does not free a slot.
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (fe_queue_o !== 128'hA1) begin n_err++; $display("FAIL fill_deq_head: got %h want a1", fe_queue_o); end
        n_cmp++; if (fe_queue_ready_o !== 1'b0) begin n_err++; $display("FAIL fill_deq_ready: got %b want 0", fe_queue_ready_o); end
        // A commit does free a slot.
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (fe_queue_ready_o !== 1'b1) begin n_err++; $display("FAIL fill_commit_ready: got %b want 1", fe_queue_ready_o); end
        n_cmp++; if (count_o !== 4'd7) begin n_err++; $display("FAIL fill_commit_count: got %0d want 7", count_o); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (count_o !== 4'd0 || fe_queue_v_o !== 1'b0) begin n_err++; $display("FAIL fill_clr: got count %0d v %b want 0 0", count_o, fe_queue_v_o); end
    endtask

    task automatic test_roll();
        for (int i = 0; i < 4; i++) drive(1'b1, 128'hA0 + 128'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (fe_queue_o !== 128'hA0 + 128'(i)) begin n_err++; $display("FAIL roll_deq%0d: got %h want %h", i, fe_queue_o, 128'hA0 + 128'(i)); end
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (fe_queue_o !== 128'hA1) begin n_err++; $display("FAIL roll_head: got %h want a1", fe_queue_o); end
        n_cmp++; if (count_o !== 4'd3) begin n_err++; $display("FAIL roll_count: got %0d want 3", count_o); end
        // Same-cycle commit and roll, with a yumi that must be ignored.
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (fe_queue_o !== 128'hA2) begin n_err++; $display("FAIL roll_commit_head: got %h want a2", fe_queue_o); end
        n_cmp++; if (count_o !== 4'd2) begin n_err++; $display("FAIL roll_commit_count: got %0d want 2", count_o); end
        // A commit with nothing dequeued is ignored.
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (count_o !== 4'd2) begin n_err++; $display("FAIL roll_idle_commit: got %0d want 2", count_o); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_clear();
        for (int i = 0; i < 5; i++) drive(1'b1, 128'hB0 + 128'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (count_o !== 4'd5) begin n_err++; $display("FAIL clr_pre_count: got %0d want 5", count_o); end
        drive(1'b1, 128'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (fe_queue_v_o !== 1'b0) begin n_err++; $display("FAIL clr_v_o: got %b want 0", fe_queue_v_o); end
        n_cmp++; if (count_o !== 4'd0) begin n_err++; $display("FAIL clr_count: got %0d want 0", count_o); end
        n_cmp++; if (fe_queue_ready_o !== 1'b1) begin n_err++; $display("FAIL clr_ready: got %b want 1", fe_queue_ready_o); end
        drive(1'b1, 128'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (fe_queue_o !== 128'h11 || count_o !== 4'd1) begin n_err++; $display("FAIL clr_next: got %h/%0d want 11/1", fe_queue_o, count_o); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 128'hC0 + 128'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (count_o !== 4'd4) begin n_err++; $display("FAIL areset_pre_count: got %0d want 4", count_o); end
        #2 reset_n_i = 1'b0;
        #1;
        n_cmp++; if (fe_queue_v_o !== 1'b0) begin n_err++; $display("FAIL areset_v_o: got %b want 0", fe_queue_v_o); end
        n_cmp++; if (fe_queue_ready_o !== 1'b1) begin n_err++; $display("FAIL areset_ready: got %b want 1", fe_queue_ready_o); end
        n_cmp++; if (count_o !== 4'd0) begin n_err++; $display("FAIL areset_count: got %0d want 0", count_o); end
        @(negedge clk_i);
        reset_n_i = 1'b1;
        drive(1'b1, 128'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (fe_queue_o !== 128'h55 || fe_queue_v_o !== 1'b1) begin n_err++; $display("FAIL areset_enq: got %h v %b want 55 1", fe_queue_o, fe_queue_v_o); end
        n_cmp++; if (dut.wptr_q !== 4'd1) begin n_err++; $display("FAIL areset_slot0: got wptr %0d want 1", dut.wptr_q); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        @(negedge clk_i);
        #1 reset_n_i = 1'b0;
        #1 reset_n_i = 1'b1;
        @(negedge clk_i);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 128'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++; if (fe_queue_v_o !== 1'b1 || fe_queue_o !== 128'(i)) begin n_err++; $display("FAIL wrap_data%0d: got %h v %b want %h", i, fe_queue_o, fe_queue_v_o, 128'(i)); end
            n_cmp++; if (count_o !== 4'd1) begin n_err++; $display("FAIL wrap_count%0d: got %0d want 1", i, count_o); end
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
            drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
            n_cmp++; if (dut.wptr_q[3] !== 1'(((i + 1) / 8) % 2) || dut.cptr_q[3] !== 1'(((i + 1) / 8) % 2)) begin
                n_err++; $display("FAIL wrap_msb%0d: got w%b c%b want %0d", i, dut.wptr_q[3], dut.cptr_q[3], ((i + 1) / 8) % 2);
            end
        end
        n_cmp++; if (count_o !== 4'd0) begin n_err++; $display("FAIL wrap_final_count: got %0d want 0", count_o); end
    endtask

    task automatic test_bypass();
        fe_queue_v_i    = 1'b1;
        fe_queue_i      = 128'h77;
        fe_queue_yumi_i = 1'b1;
        #1;
`ifdef BP_FE_QUEUE_BYPASS_EN
        n_cmp++; if (fe_queue_v_o !== 1'b1 || fe_queue_o !== 128'h77) begin n_err++; $display("FAIL byp_same_cycle: got %h v %b want 77 1", fe_queue_o, fe_queue_v_o); end
        @(posedge clk_i);
        @(negedge clk_i);
        fe_queue_v_i    = 1'b0;
        fe_queue_yumi_i = 1'b0;
        n_cmp++; if (fe_queue_v_o !== 1'b0 || count_o !== 4'd1) begin n_err++; $display("FAIL byp_consumed: got v %b count %0d want 0 1", fe_queue_v_o, count_o); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (fe_queue_v_o !== 1'b1 || fe_queue_o !== 128'h77) begin n_err++; $display("FAIL byp_replay: got %h v %b want 77 1", fe_queue_o, fe_queue_v_o); end
`else
        n_cmp++; if (fe_queue_v_o !== 1'b0) begin n_err++; $display("FAIL nobyp_same_cycle: got v %b want 0", fe_queue_v_o); end
        @(posedge clk_i);
        @(negedge clk_i);
        fe_queue_v_i    = 1'b0;
        fe_queue_yumi_i = 1'b0;
        n_cmp++; if (fe_queue_v_o !== 1'b1 || fe_queue_o !== 128'h77 || count_o !== 4'd1) begin n_err++; $display("FAIL nobyp_next: got %h v %b count %0d want 77 1 1", fe_queue_o, fe_queue_v_o, count_o); end
`endif
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        fe_queue_i      = '0;
        fe_queue_v_i    = 1'b0;
        fe_queue_yumi_i = 1'b0;
        commit_i        = 1'b0;
        roll_i          = 1'b0;
        clr_i           = 1'b0;
        test_reset();
        test_fill();
        test_roll();
        test_clear();
        test_async_reset();
        test_wrap();
        test_bypass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
